dn_time_sequencer: RTL
======================

Name: dn_time_sequencer

Overview:
- Downstream sequencer between the PC word parser and the downstream traffic consumers.
- Decodes the PC word stream into 48-bit PC-time updates, time-reset commands and data words.
- Owns the PC_time_elapsed register. Holds data words back while PC time is ahead of the wall clock, so traffic is released in wall-time order.
- Reports stall status, protocol errors and a saturating stall-cycle count.

Parameters:
- Nword, 32, data word width.
- Ntime, 48, wall/PC time width; must be even. Nhalf = Ntime/2 is the width of each time half-word.
- Nstat, 32, stall-cycle counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  input word accepted when in_valid && in_ready
- in_code  input  2  0=DATA, 1=TIME_LO, 2=TIME_HI, 3=RESET_TIME
- in_data  input  Nword  payload; time halves use in_data[Nhalf-1:0]
- time_elapsed  input  Ntime  wall time from the time manager
- out_valid  output  1  downstream word valid
- out_ready  input  1  downstream accepts
- out_data  output  Nword  downstream data word
- PC_time_elapsed  output  Ntime  committed PC time
- reset_time  output  1  one-cycle pulse telling the time manager to reset wall time
- stall_dn  output  1  PC_time_elapsed > time_elapsed
- protocol_err  output  1  sticky error flag
- stall_cycles  output  Nstat  saturating count of stalled cycles

Behaviour:
- Reset (synchronous, takes priority over all other activity):
  - state=RUN; PC_time_elapsed=0; lo_stage=0.
  - out_valid=0; out_data=0.
  - reset_time=0; protocol_err=0; stall_cycles=0.
  - Reset mid-stream discards the staged low half and any word held in the output register.
- stall_dn is combinational: 1 iff PC_time_elapsed > time_elapsed (unsigned). It is 0 when equal.
- Output register is a single entry.
  - slot_free = !out_valid || out_ready.
  - out_valid clears on out_ready when no new word is loaded in the same cycle.
  - Load and drain in the same cycle is allowed, giving 1 word/clk throughput.
- in_ready by in_code:
  - DATA: !stall_dn && slot_free
  - TIME_LO, TIME_HI: !stall_dn
  - RESET_TIME: always 1
- FSM states: RUN and WAIT_HI.
  - RUN + TIME_LO accepted: lo_stage <= in_data[Nhalf-1:0]; go to WAIT_HI.
  - RUN + TIME_HI accepted: protocol_err <= 1; word dropped; stay in RUN.
  - RUN + DATA accepted: out_data <= in_data; out_valid <= 1, on the next edge (1-cycle latency).
  - WAIT_HI + TIME_HI accepted: PC_time_elapsed <= {in_data[Nhalf-1:0], lo_stage}; go to RUN. stall_dn reflects the new value the cycle after the commit.
  - WAIT_HI + TIME_LO accepted: protocol_err <= 1; lo_stage overwritten; stay in WAIT_HI.
  - WAIT_HI + DATA accepted: protocol_err <= 1; staged half discarded; data is forwarded as in RUN; go to RUN.
- RESET_TIME accepted in any state:
  - PC_time_elapsed <= 0; state <= RUN; staged half discarded.
  - reset_time=1 for exactly one cycle, the cycle after acceptance.
  - Accepted even while stalled; this clears the stall.
  - The output register is untouched.
- A non-monotonic time update (new value < current value) is legal. It is committed as given, with no error.
- stall_cycles increments on every cycle with stall_dn=1 && in_valid=1 && in_code!=RESET_TIME. It saturates at all-ones and never wraps.
- protocol_err clears only on reset.

Test Plan:
- Pass-through: PC=0, wall=5, 4 DATA words 0xA0..0xA3 back-to-back with out_ready=1 -> out_valid from cycle+1, 4 consecutive outputs in order, in_ready stays 1.
- Time gate: TIME_LO 0x000010, TIME_HI 0x000000, then DATA 0xBEEF with wall=0x0C.
  - PC_time_elapsed=0x10; stall_dn=1; in_ready=0 on DATA.
  - stall_cycles counts until wall reaches 0x10; DATA released the cycle after wall==0x10.
- Backpressure: out_ready=0 with 2 DATA words -> first held on out_data, second blocked (in_ready=0). Raise out_ready -> both delivered, no loss or duplication.
- Reset time while stalled: PC=0x100, wall=0x20, RESET_TIME -> accepted immediately; PC_time_elapsed=0; reset_time pulses 1 cycle; stall_dn=0.
- Protocol errors:
  - TIME_HI in RUN -> protocol_err=1, PC unchanged.
  - TIME_LO then DATA 0x55 -> 0x55 forwarded, state RUN, PC unchanged.
- Reset mid-operation: assert reset in WAIT_HI with out_valid=1 -> next cycle out_valid=0, state RUN, PC=0, protocol_err=0, stall_cycles=0.

Source files
------------

// File: rtl/dn_time_sequencer.sv
// Downstream time sequencer: decodes the PC word stream into PC-time
// updates, wall-time reset requests and data words, and holds data back
// while committed PC time is ahead of wall time.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | idle / streaming, no low time half staged
// ST_WAIT_HI | low time half staged, waiting for the matching high half
module dn_time_sequencer #(
   parameter int Nword = 32,
   parameter int Ntime = 48,
   parameter int Nstat = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_code,
   input  logic [Nword-1:0] in_data,
   input  logic [Ntime-1:0] time_elapsed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Nword-1:0] out_data,
   output logic [Ntime-1:0] PC_time_elapsed,
   output logic             reset_time,
   output logic             stall_dn,
   output logic             protocol_err,
   output logic [Nstat-1:0] stall_cycles
);

   localparam int Nhalf = Ntime / 2;

   localparam logic [1:0] CODE_DATA    = 2'd0;
   localparam logic [1:0] CODE_TIME_LO = 2'd1;
   localparam logic [1:0] CODE_TIME_HI = 2'd2;
   localparam logic [1:0] CODE_RESET   = 2'd3;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_WAIT_HI = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [Nhalf-1:0] r_lo_stage;
   logic [Ntime-1:0] r_pc_time;
   logic             r_out_valid;
   logic [Nword-1:0] r_out_data;
   logic             r_reset_time;
   logic             r_protocol_err;
   logic [Nstat-1:0] r_stall_cycles;

   logic w_stall;
   logic w_slot_free;
   logic w_in_ready;
   logic w_accept;
   logic w_load_lo;
   logic w_commit;
   logic w_load_data;
   logic w_set_err;
   logic w_clr_time;
   logic w_stall_inc;

   assign w_stall     = r_pc_time > time_elapsed;
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_accept    = in_valid && w_in_ready;
   // RESET_TIME attempts never count as stalled: they are always accepted.
   assign w_stall_inc = w_stall && in_valid && (in_code != CODE_RESET);

   // Input handshake: data needs a free output slot, time words only need
   // the stall to be clear, wall-time resets are always taken.
   always_comb begin
      w_in_ready = 1'b0;
      case (in_code)
         CODE_DATA:    w_in_ready = !w_stall && w_slot_free;
         CODE_TIME_LO: w_in_ready = !w_stall;
         CODE_TIME_HI: w_in_ready = !w_stall;
         CODE_RESET:   w_in_ready = 1'b1;
         default:      w_in_ready = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and datapath strobes for the accepted word.
   always_comb begin
      w_state_nxt = r_state;
      w_load_lo   = 1'b0;
      w_commit    = 1'b0;
      w_load_data = 1'b0;
      w_set_err   = 1'b0;
      w_clr_time  = 1'b0;
      if (w_accept) begin
         case (in_code)
            CODE_DATA: begin
               w_load_data = 1'b1;
               if (r_state == ST_WAIT_HI) begin
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            CODE_TIME_LO: begin
               w_load_lo   = 1'b1;
               w_state_nxt = ST_WAIT_HI;
               if (r_state == ST_WAIT_HI) begin
                  w_set_err = 1'b1;
               end
            end
            CODE_TIME_HI: begin
               if (r_state == ST_WAIT_HI) begin
                  w_commit    = 1'b1;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_set_err = 1'b1;
               end
            end
            CODE_RESET: begin
               w_clr_time  = 1'b1;
               w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   // Time staging, PC time commit, reset pulse and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lo_stage     <= '0;
         r_pc_time      <= '0;
         r_reset_time   <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         if (w_load_lo) begin
            r_lo_stage <= in_data[Nhalf-1:0];
         end
         if (w_commit) begin
            r_pc_time <= {in_data[Nhalf-1:0], r_lo_stage};
         end else if (w_clr_time) begin
            r_pc_time <= '0;
         end
         r_reset_time <= w_clr_time;
         if (w_set_err) begin
            r_protocol_err <= 1'b1;
         end
      end
   end

   // Single-entry output register; load and drain may share a cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load_data) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating count of cycles where a word was presented while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (w_stall_inc && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + Nstat'(1);
      end
   end

   assign in_ready        = w_in_ready;
   assign out_valid       = r_out_valid;
   assign out_data        = r_out_data;
   assign PC_time_elapsed = r_pc_time;
   assign reset_time      = r_reset_time;
   assign stall_dn        = w_stall;
   assign protocol_err    = r_protocol_err;
   assign stall_cycles    = r_stall_cycles;

endmodule
